// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar beam scan scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    BURST,
    LISTEN,
    REPORT
  } scan_state_t;

  localparam int DEF_RANGE_WIDTH = 16;
  localparam int DEF_ANGLE_MIN   = -30;
  localparam int DEF_ANGLE_MAX   = 30;
  localparam int DEF_ANGLE_STEP  = 10;

  // Reported in place of a range when no echo arrived during the listen window.
  localparam logic [DEF_RANGE_WIDTH-1:0] NO_ECHO_RANGE = '1;

endpackage

// File: rtl/beam_scan_scheduler_if.sv
// Control/report bundle between the scan scheduler and its neighbours.
interface beam_scan_scheduler_if #(
  parameter int ANGLE_WIDTH = 7,
  parameter int RANGE_WIDTH = 16,
  parameter int TIME_WIDTH  = 24
);
  logic                          enable_in;
  logic                          tof_valid_in;
  logic [RANGE_WIDTH-1:0]        range_in;
  logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
  logic                          burst_start_out;
  logic                          tx_enable_out;
  logic                          dp_clear_out;
  logic [TIME_WIDTH-1:0]         time_since_emission_out;
  logic                          range_valid_out;
  logic [RANGE_WIDTH-1:0]        range_out;
  logic signed [ANGLE_WIDTH-1:0] range_angle_out;
  logic                          no_echo_out;
  logic                          sweep_done_out;

  modport master (
    output enable_in, tof_valid_in, range_in,
    input  beam_angle_out, burst_start_out, tx_enable_out, dp_clear_out,
           time_since_emission_out, range_valid_out, range_out,
           range_angle_out, no_echo_out, sweep_done_out
  );

  modport slave (
    input  enable_in, tof_valid_in, range_in,
    output beam_angle_out, burst_start_out, tx_enable_out, dp_clear_out,
           time_since_emission_out, range_valid_out, range_out,
           range_angle_out, no_echo_out, sweep_done_out
  );
endinterface

// File: rtl/angle_sequencer.sv
// Steered-angle register with step/wrap logic; define SCAN_PINGPONG_EN for
// a reversing (ping-pong) sweep instead of wrapping from max back to min.
module angle_sequencer #(
  parameter int ANGLE_WIDTH = 7,
  parameter int ANGLE_MIN   = -30,
  parameter int ANGLE_MAX   = 30,
  parameter int ANGLE_STEP  = 10
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          step,
  output logic signed [ANGLE_WIDTH-1:0] angle,
  output logic                          at_end
);

  localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

  logic up;

`ifdef SCAN_PINGPONG_EN
  // The end reached depends on the direction of travel.
  assign at_end = up ? (angle == A_MAX) : (angle == A_MIN);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      angle <= A_MIN;
      up    <= 1'b1;
    end else if (step) begin
      if (up) begin
        if (angle == A_MAX) begin
          angle <= angle - A_STEP;
          up    <= 1'b0;
        end else begin
          angle <= angle + A_STEP;
        end
      end else begin
        if (angle == A_MIN) begin
          angle <= angle + A_STEP;
          up    <= 1'b1;
        end else begin
          angle <= angle - A_STEP;
        end
      end
    end
  end
`else
  assign at_end = up && (angle == A_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      angle <= A_MIN;
      up    <= 1'b1;
    end else if (step) begin
      angle <= at_end ? A_MIN : angle + A_STEP;
      up    <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/beam_scan_scheduler.sv
// Per-angle transmit/receive dwell sequencer with first-echo range capture.
// Sweep shape selected by SCAN_PINGPONG_EN (see angle_sequencer).
module beam_scan_scheduler
  import sonar_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int SETTLE_CYCLES = 64,
  parameter int ANGLE_WIDTH   = 7,
  parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
  parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
  parameter int RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  beam_scan_scheduler_if.slave  bus
);

  localparam int TIME_WIDTH    = $clog2(PERIOD_CYCLES);
  localparam int LISTEN_CYCLES = PERIOD_CYCLES - SETTLE_CYCLES - BURST_CYCLES - 1;
  localparam logic [TIME_WIDTH-1:0] SETTLE_LAST = TIME_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] BURST_LAST  = TIME_WIDTH'(BURST_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] LISTEN_LAST = TIME_WIDTH'(LISTEN_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] TIME_MAX    = TIME_WIDTH'(PERIOD_CYCLES - 1);

  scan_state_t state, state_next;
  logic [TIME_WIDTH-1:0]         cnt;
  logic [TIME_WIDTH-1:0]         tse;
  logic                          captured;
  logic [RANGE_WIDTH-1:0]        cap_range;
  logic                          step;
  logic                          at_end;
  logic signed [ANGLE_WIDTH-1:0] angle;

  logic                          dp_clear, burst_start, tx_enable;
  logic                          range_valid, no_echo, sweep_done;
  logic [RANGE_WIDTH-1:0]        range_q;
  logic signed [ANGLE_WIDTH-1:0] range_angle;

  logic                          settle_entry, burst_entry, capture_now, echo_seen;
  logic [RANGE_WIDTH-1:0]        echo_range;

  angle_sequencer #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ANGLE_MIN   (ANGLE_MIN),
    .ANGLE_MAX   (ANGLE_MAX),
    .ANGLE_STEP  (ANGLE_STEP)
  ) u_angle (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .step   (step),
    .angle  (angle),
    .at_end (at_end)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.enable_in) state_next = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_next = BURST;
      BURST:   if (cnt == BURST_LAST) state_next = LISTEN;
      LISTEN:  if (cnt == LISTEN_LAST) state_next = REPORT;
      REPORT:  state_next = bus.enable_in ? SETTLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  assign settle_entry = (state_next == SETTLE) && (state != SETTLE);
  assign burst_entry  = (state_next == BURST) && (state != BURST);
  assign step         = (state == REPORT) && (state_next == SETTLE);
  // A strobe on the final LISTEN cycle must still reach the REPORT registers.
  assign capture_now  = (state == LISTEN) && bus.tof_valid_in && !captured;
  assign echo_seen    = captured || capture_now;
  assign echo_range   = captured ? cap_range : bus.range_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      tse         <= '0;
      captured    <= 1'b0;
      cap_range   <= '0;
      dp_clear    <= 1'b0;
      burst_start <= 1'b0;
      tx_enable   <= 1'b0;
      range_valid <= 1'b0;
      sweep_done  <= 1'b0;
      no_echo     <= 1'b0;
      range_q     <= '0;
      range_angle <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state || state == IDLE) ? '0 : cnt + 1'b1;

      dp_clear    <= settle_entry;
      burst_start <= burst_entry;
      tx_enable   <= (state_next == BURST);
      range_valid <= (state_next == REPORT);
      sweep_done  <= (state_next == REPORT) && at_end;

      if (state_next == IDLE || state_next == SETTLE || burst_entry)
        tse <= '0;
      else if (tse != TIME_MAX)
        tse <= tse + 1'b1;

      if (settle_entry) begin
        captured  <= 1'b0;
        cap_range <= '0;
      end else if (capture_now) begin
        captured  <= 1'b1;
        cap_range <= bus.range_in;
      end

      if (state_next == REPORT) begin
        range_q     <= echo_seen ? echo_range : NO_ECHO_RANGE;
        no_echo     <= !echo_seen;
        range_angle <= angle;
      end
    end
  end

  assign bus.beam_angle_out          = angle;
  assign bus.burst_start_out         = burst_start;
  assign bus.tx_enable_out           = tx_enable;
  assign bus.dp_clear_out            = dp_clear;
  assign bus.time_since_emission_out = tse;
  assign bus.range_valid_out         = range_valid;
  assign bus.range_out               = range_q;
  assign bus.range_angle_out         = range_angle;
  assign bus.no_echo_out             = no_echo;
  assign bus.sweep_done_out          = sweep_done;

endmodule

// File: tb/tb_beam_scan_scheduler.sv
// Directed bench for beam_scan_scheduler with a short dwell (100/10/4 clocks).
module tb_beam_scan_scheduler;

  localparam int PERIOD = 100;
  localparam int BURSTC = 10;
  localparam int SETTLC = 4;
  localparam int TW     = $clog2(PERIOD);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  beam_scan_scheduler_if #(.ANGLE_WIDTH(7), .RANGE_WIDTH(16), .TIME_WIDTH(TW)) bus ();

  beam_scan_scheduler #(
    .PERIOD_CYCLES (PERIOD),
    .BURST_CYCLES  (BURSTC),
    .SETTLE_CYCLES (SETTLC)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".angle"},       int'($signed(bus.beam_angle_out)), -30);
    check({tag, ".burst_start"}, int'(bus.burst_start_out), 0);
    check({tag, ".tx_enable"},   int'(bus.tx_enable_out), 0);
    check({tag, ".dp_clear"},    int'(bus.dp_clear_out), 0);
    check({tag, ".tse"},         int'(bus.time_since_emission_out), 0);
    check({tag, ".range_valid"}, int'(bus.range_valid_out), 0);
    check({tag, ".range"},       int'(bus.range_out), 0);
    check({tag, ".range_angle"}, int'($signed(bus.range_angle_out)), 0);
    check({tag, ".no_echo"},     int'(bus.no_echo_out), 0);
    check({tag, ".sweep_done"},  int'(bus.sweep_done_out), 0);
  endtask

  // Runs one dwell from the cycle before SETTLE entry through its REPORT cycle.
  task automatic dwell(input string name, input int t1, input int t2, input bit blank_tof,
                       input logic [15:0] r1, input int drop_at, input int exp_ang,
                       input int exp_range, input int exp_no, input int exp_sweep);
    int bs = -1, rv = -1, dc = -1, ntx = 0, ndc = 0;
    int rng = 0, no = 0, ang = 0, sw = 0, tse_rep = 0, tse;
    for (int c = 1; c <= 150 && rv < 0; c++) begin
      @(negedge clk);
      bus.tof_valid_in = 1'b0;
      if (c == drop_at) bus.enable_in = 1'b0;
      tse = int'(bus.time_since_emission_out);
      if (bus.dp_clear_out) begin
        ndc++;
        if (dc < 0) dc = c;
      end
      if (bus.burst_start_out && bs < 0) bs = c;
      if (bus.tx_enable_out) begin
        ntx++;
        if (blank_tof && tse == 3) begin
          bus.tof_valid_in = 1'b1;
          bus.range_in     = 16'h0777;
        end
      end else if (!bus.range_valid_out && tse != 0 && (tse == t1 || tse == t2)) begin
        bus.tof_valid_in = 1'b1;
        bus.range_in     = (tse == t1) ? r1 : 16'h0456;
      end
      if (bus.range_valid_out) begin
        rv      = c;
        rng     = int'(bus.range_out);
        no      = int'(bus.no_echo_out);
        ang     = int'($signed(bus.range_angle_out));
        sw      = int'(bus.sweep_done_out);
        tse_rep = tse;
      end
    end
    check({name, ".report_cycle"}, rv, PERIOD);
    check({name, ".dp_clear_cycle"}, dc, 1);
    check({name, ".dp_clear_count"}, ndc, 1);
    check({name, ".burst_start_cycle"}, bs, SETTLC + 1);
    check({name, ".tx_cycles"}, ntx, BURSTC);
    check({name, ".tse_at_report"}, tse_rep, PERIOD - SETTLC - 1);
    check({name, ".range"}, rng, exp_range);
    check({name, ".no_echo"}, no, exp_no);
    check({name, ".range_angle"}, ang, exp_ang);
    check({name, ".sweep_done"}, sw, exp_sweep);
  endtask

  int exp_ang [9];
  int held_ang;
  int seen_bad;
  bit got_burst;

  initial begin
`ifdef SCAN_PINGPONG_EN
    exp_ang = '{-30, -20, -10, 0, 10, 20, 30, 20, 10};
`else
    exp_ang = '{-30, -20, -10, 0, 10, 20, 30, -30, -20};
`endif
    bus.enable_in    = 1'b0;
    bus.tof_valid_in = 1'b0;
    bus.range_in     = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.tx_enable", int'(bus.tx_enable_out), 0);
    check("idle.dp_clear", int'(bus.dp_clear_out), 0);

    bus.enable_in = 1'b1;
    dwell("d1_echo",     40, 60, 1'b0, 16'h0123, -1, exp_ang[0], 16'h0123, 0, 0);
    dwell("d2_blank",    -1, -1, 1'b1, 16'h0000, -1, exp_ang[1], 16'hFFFF, 1, 0);
    dwell("d3_last",     94, -1, 1'b0, 16'h0ABC, -1, exp_ang[2], 16'h0ABC, 0, 0);
    for (int d = 3; d < 8; d++)
      dwell($sformatf("d%0d", d + 1), -1, -1, 1'b0, 16'h0000, -1, exp_ang[d], 16'hFFFF, 1,
            (d == 6) ? 1 : 0);

    dwell("d9_drop", -1, -1, 1'b0, 16'h0000, 50, exp_ang[8], 16'hFFFF, 1, 0);
    seen_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.range_valid_out || bus.tx_enable_out || bus.dp_clear_out ||
          bus.time_since_emission_out != 0) seen_bad++;
    end
    check("idle_after_drop.activity", seen_bad, 0);
    check("idle_after_drop.angle_held", int'($signed(bus.beam_angle_out)), exp_ang[8]);

    bus.enable_in = 1'b1;
    got_burst = 1'b0;
    for (int c = 0; c < 30 && !got_burst; c++) begin
      @(negedge clk);
      if (bus.tx_enable_out && bus.time_since_emission_out == 3) got_burst = 1'b1;
    end
    check("resume.burst_seen", int'(got_burst), 1);
    check("resume.angle", int'($signed(bus.beam_angle_out)), exp_ang[8]);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    rst = 1'b1;
    bus.enable_in = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
